// File: rtl/mt_decode_issue.sv
// Decode/issue stage for the multithreaded RV32I pipeline, between fetch and execute.
// Extracts register fields and keeps a per-thread scoreboard of pending register writes.
// An instruction stalls while any register it uses is still in flight for its own thread.
// Accepted instructions go to execute through a ready/valid output register.
// A per-thread flush kills whatever that thread has in this stage.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   valid_f/ready_f               fetch handshake (ready_f is combinational)
//   instr_f, pc_f, tid_f          fetched instruction, PC and thread id
//   valid_d/ready_e               execute handshake
//   instr_d, pc_d, tid_d          registered instruction, PC and thread id
//   rs1_d, rs2_d, rd_d            registered register fields
//   writes_rd_d                   held instruction writes a nonzero rd
//   wb_valid_w, wb_rd_w, wb_tid_w writeback retiring a register write
//   flush_valid, flush_tid        kill everything of flush_tid in this stage
//   stall_cycles                  saturating count of fetch-valid hazard cycles
module mt_decode_issue #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned NUM_THREADS   = 4,
  parameter int unsigned NUM_REGS      = 32,
  localparam int unsigned BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_f,
  output logic                     ready_f,
  input  logic [31:0]              instr_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_f,
  input  logic [BITS_THREADS-1:0]  tid_f,
  output logic                     valid_d,
  input  logic                     ready_e,
  output logic [31:0]              instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [BITS_THREADS-1:0]  tid_d,
  output logic [4:0]               rs1_d,
  output logic [4:0]               rs2_d,
  output logic [4:0]               rd_d,
  output logic                     writes_rd_d,
  input  logic                     wb_valid_w,
  input  logic [4:0]               wb_rd_w,
  input  logic [BITS_THREADS-1:0]  wb_tid_w,
  input  logic                     flush_valid,
  input  logic [BITS_THREADS-1:0]  flush_tid,
  output logic [31:0]              stall_cycles
);

  logic [NUM_THREADS-1:0][NUM_REGS-1:0] busy_q, busy_d;

  logic                     valid_q;
  logic [31:0]              instr_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [BITS_THREADS-1:0]  tid_q;
  logic [4:0]               rs1_q, rs2_q, rd_q;
  logic                     writes_rd_q;
  logic [31:0]              stall_q;

  logic [6:0] opcode;
  logic [4:0] rs1_f, rs2_f, rd_f;
  logic       uses_rd, uses_rs1, uses_rs2;
  logic       hazard, block_flush, accept, flush_kill, writes_rd_f;

  assign opcode = instr_f[6:0];
  assign rs1_f  = instr_f[19:15];
  assign rs2_f  = instr_f[24:20];
  assign rd_f   = instr_f[11:7];

  always_comb begin
    uses_rd  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      7'b0110011: begin uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0010011,
      7'b0000011,
      7'b1100111: begin uses_rd = 1'b1; uses_rs1 = 1'b1; end
      7'b0100011,
      7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1101111,
      7'b0110111,
      7'b0010111: uses_rd = 1'b1;
      default: ;
    endcase
  end

  // A writeback landing this cycle already satisfies the dependency.
  function automatic logic busy_eff(input logic [BITS_THREADS-1:0] t, input logic [4:0] r);
    return (r != 5'd0) && busy_q[t][r] && !(wb_valid_w && (wb_tid_w == t) && (wb_rd_w == r));
  endfunction

  assign writes_rd_f = uses_rd && (rd_f != 5'd0);
  assign hazard      = (uses_rs1 && busy_eff(tid_f, rs1_f)) ||
                       (uses_rs2 && busy_eff(tid_f, rs2_f)) ||
                       (uses_rd  && busy_eff(tid_f, rd_f));
  assign block_flush = flush_valid && (flush_tid == tid_f);
  assign ready_f     = (!valid_q || ready_e) && !hazard && !block_flush;
  assign accept      = valid_f && ready_f;
  assign flush_kill  = flush_valid && valid_q && (tid_q == flush_tid);

  // Order matters: clears first, then the issue-time set so it wins on a collision.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_w && (wb_rd_w != 5'd0)) busy_d[wb_tid_w][wb_rd_w] = 1'b0;
    // The killed instruction will never write back, so release its destination here.
    if (flush_kill && writes_rd_q) busy_d[tid_q][rd_q] = 1'b0;
    if (accept && writes_rd_f) busy_d[tid_f][rd_f] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      pc_q        <= '0;
      tid_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      writes_rd_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        valid_q     <= 1'b1;
        instr_q     <= instr_f;
        pc_q        <= pc_f;
        tid_q       <= tid_f;
        rs1_q       <= rs1_f;
        rs2_q       <= rs2_f;
        rd_q        <= rd_f;
        writes_rd_q <= writes_rd_f;
      end else if (flush_kill || ready_e) begin
        valid_q <= 1'b0;
      end
      if (valid_f && hazard && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign valid_d      = valid_q;
  assign instr_d      = instr_q;
  assign pc_d         = pc_q;
  assign tid_d        = tid_q;
  assign rs1_d        = rs1_q;
  assign rs2_d        = rs2_q;
  assign rd_d         = rd_q;
  assign writes_rd_d  = writes_rd_q;
  assign stall_cycles = stall_q;

endmodule
